sdram_port_arbiter: RTL

Multi-client front end for the SDRAM controller. N word-addressed stb/ack clients share one downstream stb/ack port. The block provides round-robin or fixed-priority arbitration, per-byte write enables and a response timeout. It sits between the GPU/CPU-side masters and the SDRAM interface, in that interface's clock domain.

---
 rtl/sdram_arb_pkg.sv | 13 +
 rtl/rr_pick.sv | 32 +++
 rtl/sdram_port_arbiter.sv | 109 ++++++++++
 3 files changed

// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared state encoding and sizing helpers for the SDRAM port arbiter
package sdram_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int sel_width(input int dw);
    return dw / 8;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational request picker, round-robin from ptr+1 or fixed priority (port 0 highest)
//   req  - request vector
//   ptr  - last granted index (round-robin only)
//   gnt  - one-hot grant, zero when no request
//   idx  - granted index
//   any  - at least one request present
module rr_pick
  import sdram_arb_pkg::*;
#(
  parameter int N = 4,
  parameter bit FIXED = 1'b0,
  localparam int IW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  int j;
  assign any = |req;
  always_comb begin
    idx = '0;
    j = 0;
    // walk from lowest to highest priority so the last hit is the winner
    for (int i = N; i >= 1; i--) begin
      j = FIXED ? i - 1 : (int'(ptr) + i) % N;
      if (req[j]) idx = IW'(j);
    end
    gnt = any ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: N-client stb/ack front end sharing one downstream SDRAM port
//   clk, rst_n              - clock, asynchronous active-low reset
//   c_stb/c_we/c_addr/
//   c_wdata/c_sel           - per-client request fields, held until c_ack or c_err
//   c_rdata                 - shared read data, valid with the reading port's c_ack
//   c_ack / c_err           - one-cycle completion / timeout-abort pulses
//   m_stb/m_we/m_addr/
//   m_sel/m_wdata           - registered downstream request
//   m_rdata / m_ack         - downstream response
//   busy                    - transaction in flight (ISSUE or RESP)
//   err_sticky              - a timeout has occurred since reset
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int N_PORTS = 4,
  parameter int DW = 32,
  parameter int AW = 24,
  parameter bit FIXED_PRIO = 1'b0,
  parameter int TIMEOUT = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_PORTS-1:0]          c_stb,
  input  logic [N_PORTS-1:0]          c_we,
  input  logic [N_PORTS*AW-1:0]       c_addr,
  input  logic [N_PORTS*DW-1:0]       c_wdata,
  input  logic [N_PORTS*(DW/8)-1:0]   c_sel,
  output logic [DW-1:0]               c_rdata,
  output logic [N_PORTS-1:0]          c_ack,
  output logic [N_PORTS-1:0]          c_err,
  output logic                        m_stb,
  output logic                        m_we,
  output logic [AW-1:0]               m_addr,
  output logic [DW/8-1:0]             m_sel,
  output logic [DW-1:0]               m_wdata,
  input  logic [DW-1:0]               m_rdata,
  input  logic                        m_ack,
  output logic                        busy,
  output logic                        err_sticky
);
  localparam int SW = sel_width(DW);
  localparam int IW = clog2(N_PORTS);
  localparam int CW = clog2(TIMEOUT + 1);
  state_t state, state_n;
  logic [IW-1:0] ptr, pick_idx;
  logic [N_PORTS-1:0] pick_gnt, g_oh;
  logic pick_any, expired;
  logic [CW-1:0] cnt;
  rr_pick #(.N(N_PORTS), .FIXED(FIXED_PRIO)) u_pick (
    .req(c_stb),
    .ptr(ptr),
    .gnt(pick_gnt),
    .idx(pick_idx),
    .any(pick_any)
  );
  assign expired = (TIMEOUT > 0) && (cnt == CW'(TIMEOUT - 1));
  always_comb begin
    state_n = state == IDLE  ? (pick_any ? ISSUE : IDLE) :
              state == ISSUE ? ((m_ack || expired) ? RESP : ISSUE) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= IW'(N_PORTS - 1);
      g_oh <= '0;
      cnt <= '0;
      c_rdata <= '0;
      c_ack <= '0;
      c_err <= '0;
      m_stb <= 1'b0;
      m_we <= 1'b0;
      m_addr <= '0;
      m_sel <= '0;
      m_wdata <= '0;
      busy <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      c_ack <= '0;
      c_err <= '0;
      busy <= state_n != IDLE;
      if (state == IDLE && pick_any) begin
        ptr <= pick_idx;
        g_oh <= pick_gnt;
        cnt <= '0;
        m_stb <= 1'b1;
        m_we <= c_we[pick_idx];
        m_addr <= c_addr[pick_idx*AW +: AW];
        m_wdata <= c_wdata[pick_idx*DW +: DW];
        m_sel <= c_we[pick_idx] ? c_sel[pick_idx*SW +: SW] : '1;
      end
      if (state == ISSUE) begin
        if (m_ack) begin
          m_stb <= 1'b0;
          c_ack <= g_oh;
          if (!m_we) c_rdata <= m_rdata;
        end else if (expired) begin
          m_stb <= 1'b0;
          c_err <= g_oh;
          err_sticky <= 1'b1;
        end else if (cnt != '1) begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end
endmodule
